// File: rtl/cfg_stream_pkg.sv
// Shared FSM state type, CRC constants and bus-slicing helpers for cfg_stream_loader.
// Defining CFG_STREAM_CRC_EN adds the CHECK state used for the CRC trailer word.
package cfg_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT_CH,
    S_FETCH,
    S_SHIFT,
    S_GAP,
`ifdef CFG_STREAM_CRC_EN
    S_CHECK,
`endif
    S_DONE
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Channel c's field starts c*width bits into the packed per-channel bus.
  function automatic int unsigned frame_len_base(input int unsigned ch, input int unsigned len_w);
    return ch * len_w;
  endfunction

  function automatic int unsigned elem_cnt_base(input int unsigned ch, input int unsigned cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF), one bit per enabled cycle.
// Only instantiated when CFG_STREAM_CRC_EN is defined.
module cfg_crc16_serial
  import cfg_stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ bit_in;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/cfg_stream_loader.sv
// Streams host words LSB-first onto N_CH configuration chains with per-channel framing.
// Build option CFG_STREAM_CRC_EN appends a CRC-16 trailer check after the last channel.
module cfg_stream_loader
  import cfg_stream_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int DW    = 32,
  parameter int LEN_W = 12,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_CH*LEN_W-1:0] frame_len_i,
  input  logic [N_CH*CNT_W-1:0] elem_cnt_i,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [N_CH-1:0]       cfg_bit_o,
  output logic [N_CH-1:0]       cfg_en_o,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_err
);

  localparam int IDX_W    = $clog2(DW) + 1;
  localparam int CH_W     = $clog2(N_CH + 1);
  localparam int CH_SLOTS = 2 ** CH_W;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [DW-1:0]    word_q, word_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [CNT_W-1:0] elem_left_q, elem_left_d;
  logic             cur_bit;
  logic [N_CH-1:0]  lane_onehot;

  // Tables padded to a power of two so the end-of-channels index reads a zero entry.
  logic [LEN_W-1:0] len_tab [CH_SLOTS];
  logic [CNT_W-1:0] cnt_tab [CH_SLOTS];

  for (genvar c = 0; c < CH_SLOTS; c++) begin : g_tab
    if (c < N_CH) begin : g_used
      assign len_tab[c] = frame_len_i[frame_len_base(c, LEN_W) +: LEN_W];
      assign cnt_tab[c] = elem_cnt_i[elem_cnt_base(c, CNT_W) +: CNT_W];
    end else begin : g_pad
      assign len_tab[c] = '0;
      assign cnt_tab[c] = '0;
    end
  end

  assign cur_bit     = word_q[bit_idx_q[IDX_W-2:0]];
  assign lane_onehot = N_CH'(1) << ch_q;

`ifdef CFG_STREAM_CRC_EN
  logic        crc_clr;
  logic        crc_err_q, crc_err_d;
  logic [15:0] crc_val;

  cfg_crc16_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (crc_clr),
    .en     (|cfg_en_o),
    .bit_in (|cfg_bit_o),
    .crc    (crc_val)
  );

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    word_d      = word_q;
    bit_idx_d   = bit_idx_q;
    bit_cnt_d   = bit_cnt_q;
    frame_len_d = frame_len_q;
    elem_left_d = elem_left_q;
    s_ready     = 1'b0;
    cfg_en_o    = '0;
    cfg_bit_o   = '0;
`ifdef CFG_STREAM_CRC_EN
    crc_clr     = 1'b0;
    crc_err_d   = crc_err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_NEXT_CH;
          ch_d    = '0;
`ifdef CFG_STREAM_CRC_EN
          crc_clr   = 1'b1;
          crc_err_d = 1'b0;
`endif
        end
      end

      S_NEXT_CH: begin
        if (ch_q == CH_W'(N_CH)) begin
`ifdef CFG_STREAM_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (len_tab[ch_q] == '0 || cnt_tab[ch_q] == '0) begin
          ch_d = ch_q + CH_W'(1);
        end else begin
          frame_len_d = len_tab[ch_q];
          elem_left_d = cnt_tab[ch_q];
          bit_cnt_d   = '0;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          word_d    = s_data;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        cfg_en_o  = lane_onehot;
        cfg_bit_o = cur_bit ? lane_onehot : '0;
        bit_idx_d = bit_idx_q + IDX_W'(1);
        if (bit_cnt_q == frame_len_q - LEN_W'(1)) begin
          bit_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (bit_idx_q == IDX_W'(DW - 1)) state_d = S_FETCH;
        end
      end

      S_GAP: begin
        elem_left_d = elem_left_q - CNT_W'(1);
        if (elem_left_q > CNT_W'(1)) begin
          // Elements continue mid-word; only an exhausted word forces a fetch.
          state_d = (bit_idx_q == IDX_W'(DW)) ? S_FETCH : S_SHIFT;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_NEXT_CH;
        end
      end

`ifdef CFG_STREAM_CRC_EN
      S_CHECK: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_data[15:0] != crc_val) crc_err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      word_q      <= '0;
      bit_idx_q   <= '0;
      bit_cnt_q   <= '0;
      frame_len_q <= '0;
      elem_left_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_len_q <= frame_len_d;
      elem_left_q <= elem_left_d;
    end
  end

`ifdef CFG_STREAM_CRC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_err_q <= 1'b0;
    else       crc_err_q <= crc_err_d;
  end
`endif

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed self-checking bench for cfg_stream_loader; with CFG_STREAM_CRC_EN defined every
// load is followed by a CRC trailer word and the CRC scenario is also exercised.
module tb_cfg_stream_loader;

  localparam int N_CH  = 3;
  localparam int DW    = 32;
  localparam int LEN_W = 12;
  localparam int CNT_W = 4;
`ifdef CFG_STREAM_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [N_CH*LEN_W-1:0] frame_len_i = '0;
  logic [N_CH*CNT_W-1:0] elem_cnt_i = '0;
  logic [DW-1:0]         s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [N_CH-1:0]       cfg_bit_o;
  logic [N_CH-1:0]       cfg_en_o;
  logic                  busy;
  logic                  done;
  logic                  crc_err;

  cfg_stream_loader #(.N_CH(N_CH), .DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_len_i (frame_len_i),
    .elem_cnt_i  (elem_cnt_i),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cfg_bit_o   (cfg_bit_o),
    .cfg_en_o    (cfg_en_o),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] words [$];
  bit  exp_bit [$];
  int  exp_ch  [$];
  bit  got_bit [$];
  int  got_ch  [$];
  int  elem_len [$];
  int  hs, busy_cycles, first_en, bad_lane;
  bit  timed_out;
  int  stall_word = -1;
  int  stall_len = 0;
  bit  flip_crc = 1'b0;

  // Reference serialisation: each active channel starts on a fresh word, bits LSB-first.
  task automatic build_expected(input logic [N_CH*LEN_W-1:0] fl,
                                input logic [N_CH*CNT_W-1:0] ec, output int n_words);
    int f, e;
    logic [DW-1:0] w;
    exp_bit.delete();
    exp_ch.delete();
    n_words = 0;
    for (int c = 0; c < N_CH; c++) begin
      f = int'(fl[c*LEN_W +: LEN_W]);
      e = int'(ec[c*CNT_W +: CNT_W]);
      if (f != 0 && e != 0) begin
        for (int i = 0; i < f * e; i++) begin
          w = words[n_words + i / DW];
          exp_bit.push_back(w[i % DW]);
          exp_ch.push_back(c);
        end
        n_words += (f * e + DW - 1) / DW;
      end
    end
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (exp_bit[i]) begin
      fb = c[15] ^ exp_bit[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic int seq_diffs();
    int d;
    d = (got_bit.size() != exp_bit.size()) ? 1 : 0;
    for (int i = 0; i < got_bit.size() && i < exp_bit.size(); i++)
      if (got_bit[i] !== exp_bit[i] || got_ch[i] != exp_ch[i]) d++;
    return d;
  endfunction

  // Runs one load starting at the current posedge+1; cycle 0 carries the start pulse.
  task automatic run_load(input logic [N_CH*LEN_W-1:0] fl, input logic [N_CH*CNT_W-1:0] ec,
                          input int budget, input int extra_start);
    logic [DW-1:0] feed [$];
    int  n_words, wp, stall_left, en_run, lane;
    bit  take, finished;
    build_expected(fl, ec, n_words);
    for (int i = 0; i < n_words; i++) feed.push_back(words[i]);
    if (CRC_ON != 0) feed.push_back(DW'(crc_model() ^ 16'(flip_crc)));
    got_bit.delete(); got_ch.delete(); elem_len.delete();
    hs = 0; busy_cycles = 0; first_en = -1; bad_lane = 0; timed_out = 1'b0;
    wp = 0; stall_left = stall_len; en_run = 0;
    frame_len_i = fl;
    elem_cnt_i  = ec;
    for (int cyc = 0; ; cyc++) begin
      start   = (cyc == 0) || (cyc == extra_start);
      s_valid = (wp < feed.size()) && !(wp == stall_word && stall_left > 0);
      s_data  = (wp < feed.size()) ? feed[wp] : '0;
      @(negedge clk);
      if ((cfg_bit_o & ~cfg_en_o) != '0) bad_lane++;
      if (cfg_en_o != '0) begin
        if ($countones(cfg_en_o) != 1) bad_lane++;
        lane = -1;
        for (int k = 0; k < N_CH; k++) if (cfg_en_o[k]) lane = k;
        got_bit.push_back(|cfg_bit_o);
        got_ch.push_back(lane);
        en_run++;
        if (first_en < 0) first_en = cyc;
      end else if (busy && !s_ready && en_run > 0) begin
        elem_len.push_back(en_run);
        en_run = 0;
      end
      if (busy) busy_cycles++;
      take = s_valid && s_ready;
      if (s_ready && !s_valid && wp == stall_word && stall_left > 0) stall_left--;
      finished = done && cyc > 0;
      @(posedge clk);
      #1;
      if (take) begin
        wp++;
        hs++;
      end
      if (finished) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({s_ready, cfg_en_o, cfg_bit_o, busy, done, crc_err} !== '0) begin
      $display("FAIL reset_hold: outputs=%b required all 0",
               {s_ready, cfg_en_o, cfg_bit_o, busy, done, crc_err});
      tests_failed++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
      tests_failed++;
    end
    tests_run++;
    if (s_ready !== 1'b0 || cfg_en_o !== '0 || cfg_bit_o !== '0 || crc_err !== 1'b0) begin
      $display("FAIL reset_outputs: ready=%b en=%b bit=%b crc_err=%b required 0",
               s_ready, cfg_en_o, cfg_bit_o, crc_err);
      tests_failed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_channel();
    int bad;
    words = '{32'hA5C3_1E0F, 32'h1234_5678, 32'hDEAD_BEEF,
              32'h0F0F_F0F0, 32'h8000_0001, 32'hCAFE_BABE};
    run_load({12'd0, 12'd0, 12'd48}, {4'd0, 4'd0, 4'd4}, 600, -1);
    tests_run++;
    if (timed_out) begin
      $display("FAIL single_timeout: done never rose within budget");
      tests_failed++;
    end
    bad = 0;
    foreach (elem_len[i]) if (elem_len[i] != 48) bad++;
    tests_run++;
    if (elem_len.size() != 4 || bad != 0) begin
      $display("FAIL single_elements: count=%0d wrong_len=%0d required 4 elements of 48",
               elem_len.size(), bad);
      tests_failed++;
    end
    tests_run++;
    if (seq_diffs() != 0) begin
      $display("FAIL single_bits: %0d diffs, got %0d bits required %0d",
               seq_diffs(), got_bit.size(), exp_bit.size());
      tests_failed++;
    end
    tests_run++;
    if (hs != 6 + CRC_ON) begin
      $display("FAIL single_handshakes: got %0d required %0d", hs, 6 + CRC_ON);
      tests_failed++;
    end
    tests_run++;
    if (first_en != 3) begin
      $display("FAIL single_latency: first en at cycle %0d required 3", first_en);
      tests_failed++;
    end
    tests_run++;
    if (busy_cycles != 206 + CRC_ON) begin
      $display("FAIL single_busy_cycles: got %0d required %0d", busy_cycles, 206 + CRC_ON);
      tests_failed++;
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || bad_lane != 0) begin
      $display("FAIL single_end: done=%b busy=%b lane_errors=%0d required 1 0 0",
               done, busy, bad_lane);
      tests_failed++;
    end
  endtask

  task automatic test_skip_cross_word();
    words = '{32'h9E37_79B9, 32'hFFFF_FFE0, 32'h5555_AAAA};
    run_load({12'd5, 12'd37, 12'd0}, {4'd0, 4'd1, 4'd3}, 300, -1);
    tests_run++;
    if (timed_out || seq_diffs() != 0) begin
      $display("FAIL skip_bits: timeout=%0d diffs=%0d got %0d bits required 37",
               timed_out, seq_diffs(), got_bit.size());
      tests_failed++;
    end
    tests_run++;
    if (hs != 2 + CRC_ON) begin
      $display("FAIL skip_handshakes: got %0d required %0d", hs, 2 + CRC_ON);
      tests_failed++;
    end
    tests_run++;
    if (first_en != 4 || busy_cycles != 44 + CRC_ON) begin
      $display("FAIL skip_timing: first_en=%0d busy=%0d required 4 %0d",
               first_en, busy_cycles, 44 + CRC_ON);
      tests_failed++;
    end
    tests_run++;
    if (bad_lane != 0 || elem_len.size() != 1) begin
      $display("FAIL skip_lanes: lane_errors=%0d elements=%0d required 0 1",
               bad_lane, elem_len.size());
      tests_failed++;
    end
  endtask

  task automatic test_backpressure();
    stall_word = 1;
    stall_len  = 5;
    run_load({12'd5, 12'd37, 12'd0}, {4'd0, 4'd1, 4'd3}, 300, -1);
    stall_word = -1;
    stall_len  = 0;
    tests_run++;
    if (timed_out || seq_diffs() != 0) begin
      $display("FAIL stall_bits: timeout=%0d diffs=%0d", timed_out, seq_diffs());
      tests_failed++;
    end
    tests_run++;
    if (busy_cycles != 49 + CRC_ON || hs != 2 + CRC_ON) begin
      $display("FAIL stall_timing: busy=%0d hs=%0d required %0d %0d",
               busy_cycles, hs, 49 + CRC_ON, 2 + CRC_ON);
      tests_failed++;
    end
    tests_run++;
    if (elem_len.size() != 1 || (elem_len.size() == 1 && elem_len[0] != 37)) begin
      $display("FAIL stall_element: elements=%0d required one of 37", elem_len.size());
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_and_busy_start();
    logic [N_CH*LEN_W-1:0] fl;
    logic [N_CH*CNT_W-1:0] ec;
    fl = {12'd40, 12'd8, 12'd8};
    ec = {4'd2, 4'd1, 4'd1};
    words = '{32'h0000_00C3, 32'h0000_005A, 32'h1357_9BDF, 32'h2468_ACE0, 32'hF00D_0BAD};
    run_load(fl, ec, 30, -1);
    tests_run++;
    if (cfg_en_o !== 3'b100) begin
      $display("FAIL midrun_lane: en=%b required 100 before reset", cfg_en_o);
      tests_failed++;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({s_ready, cfg_en_o, cfg_bit_o, busy, done, crc_err} !== '0) begin
      $display("FAIL midrun_reset: outputs=%b required all 0",
               {s_ready, cfg_en_o, cfg_bit_o, busy, done, crc_err});
      tests_failed++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL midrun_idle: busy=%b done=%b required 0 0", busy, done);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    run_load(fl, ec, 400, 15);
    tests_run++;
    if (timed_out || seq_diffs() != 0) begin
      $display("FAIL reload_bits: timeout=%0d diffs=%0d", timed_out, seq_diffs());
      tests_failed++;
    end
    tests_run++;
    if (got_ch.size() == 0 || got_ch[0] != 0) begin
      $display("FAIL reload_first_ch: got %0d required 0",
               (got_ch.size() == 0) ? -1 : got_ch[0]);
      tests_failed++;
    end
    tests_run++;
    if (busy_cycles != 109 + CRC_ON || hs != 5 + CRC_ON) begin
      $display("FAIL busy_start: busy=%0d hs=%0d required %0d %0d",
               busy_cycles, hs, 109 + CRC_ON, 5 + CRC_ON);
      tests_failed++;
    end
  endtask

`ifdef CFG_STREAM_CRC_EN
  task automatic test_crc();
    words = '{32'h3132_3334, 32'h3536_3738, 32'h0000_0039};
    run_load({12'd0, 12'd0, 12'd32}, {4'd0, 4'd0, 4'd3}, 300, -1);
    tests_run++;
    if (timed_out || crc_err !== 1'b0 || done !== 1'b1) begin
      $display("FAIL crc_good: timeout=%0d crc_err=%b done=%b required 0 0 1",
               timed_out, crc_err, done);
      tests_failed++;
    end
    flip_crc = 1'b1;
    run_load({12'd0, 12'd0, 12'd32}, {4'd0, 4'd0, 4'd3}, 300, -1);
    flip_crc = 1'b0;
    tests_run++;
    if (timed_out || crc_err !== 1'b1 || done !== 1'b1) begin
      $display("FAIL crc_bad: timeout=%0d crc_err=%b done=%b required 0 1 1",
               timed_out, crc_err, done);
      tests_failed++;
    end
    run_load({12'd0, 12'd0, 12'd32}, {4'd0, 4'd0, 4'd3}, 1, -1);
    tests_run++;
    if (crc_err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL crc_clear: crc_err=%b busy=%b required 0 1", crc_err, busy);
      tests_failed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_channel();
    test_skip_cross_word();
    test_backpressure();
    test_reset_mid_and_busy_start();
`ifdef CFG_STREAM_CRC_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
